rsa_exp_arbiter: RTL and testbench

Round-robin scheduler that shares one modular-exponentiation engine (r = base^exp mod modulus, 32-bit) among NREQ requesters. It accepts one job at a time over a valid/ready handshake, latches the operands and fires the engine's one-cycle start pulse. It then waits for the engine's done pulse and returns the result to the owning requester. It sits between the RSA host-side request ports and the single exponentiation datapath instance.

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/rsa_exp_arbiter_if.sv | 41 ++++
 rtl/rsa_exp_arbiter_rr_pick.sv | 43 ++++
 rtl/rsa_exp_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rsa_exp_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular-exponentiation arbiter.
// The optional BUSY watchdog is compiled in with ARB_WATCHDOG_EN.
package rsa_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam int          NREQ_DEF    = 4;
   localparam int          DW_DEF      = 32;
   localparam logic [15:0] TIMEOUT_DEF = 16'd65535;

   // Width of a requester index; never narrower than one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rsa_exp_arbiter_if.sv
// Host request/response ports plus engine ports of the exponentiation arbiter.
// Operand buses are flattened: requester i occupies [i*DW +: DW].
interface rsa_exp_arbiter_if
   import rsa_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF
) ();

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_base;
   logic [NREQ*DW-1:0] req_exp;
   logic [NREQ*DW-1:0] req_mod;
   logic [NREQ-1:0]    resp_valid;
   logic [NREQ-1:0]    resp_ready;
   logic [DW-1:0]      resp_r;
   logic               resp_err;
   logic               eng_start;
   logic [DW-1:0]      eng_base;
   logic [DW-1:0]      eng_exp;
   logic [DW-1:0]      eng_mod;
   logic [DW-1:0]      eng_r;
   logic               eng_done;
   logic               busy;

   // Arbiter side.
   modport slave (
      input  req_valid, req_base, req_exp, req_mod, resp_ready, eng_r, eng_done,
      output req_ready, resp_valid, resp_r, resp_err, eng_start,
             eng_base, eng_exp, eng_mod, busy
   );

   // Requesters plus engine side.
   modport master (
      output req_valid, req_base, req_exp, req_mod, resp_ready, eng_r, eng_done,
      input  req_ready, resp_valid, resp_r, resp_err, eng_start,
             eng_base, eng_exp, eng_mod, busy
   );

endinterface

// File: rtl/rsa_exp_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping, returned as one-hot grant and binary index.
module rr_pick
   import rsa_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int PW   = ptr_w(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [PW-1:0]   o_idx,
   output logic            o_any
);

   logic [PW:0]     w_sum [NREQ];
   logic [PW-1:0]   w_pos [NREQ];
   logic [NREQ-1:0] w_hit;

   // Slot gi of the rotated view holds requester (ptr + gi) mod NREQ.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
         assign w_sum[gi] = {1'b0, i_ptr} + (PW+1)'(gi);
         assign w_pos[gi] = (w_sum[gi] >= (PW+1)'(NREQ))
                          ? PW'(w_sum[gi] - (PW+1)'(NREQ))
                          : w_sum[gi][PW-1:0];
         assign w_hit[gi] = i_req[w_pos[gi]];
      end
   endgenerate

   always_comb begin
      o_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            o_idx = w_pos[k];
         end
      end
   end

   assign o_any   = |i_req;
   assign o_grant = o_any ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/rsa_exp_arbiter.sv
// Round-robin scheduler sharing one modular-exponentiation engine among NREQ
// requesters; optional BUSY watchdog enabled by defining ARB_WATCHDOG_EN.
module rsa_exp_arbiter
   import rsa_pkg::*;
#(
   parameter int          NREQ    = NREQ_DEF,
   parameter int          DW      = DW_DEF,
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   rsa_exp_arbiter_if.slave bus
);

   localparam int PW = ptr_w(NREQ);

   state_e          r_state;
   state_e          w_state_next;
   logic [PW-1:0]   r_rr_ptr;
   logic [PW-1:0]   r_owner;
   logic [DW-1:0]   r_eng_base;
   logic [DW-1:0]   r_eng_exp;
   logic [DW-1:0]   r_eng_mod;
   logic [DW-1:0]   r_resp_r;
   logic            r_resp_err;

   logic [NREQ-1:0] w_grant;
   logic [PW-1:0]   w_idx;
   logic            w_any;
   logic [DW-1:0]   w_win_base;
   logic [DW-1:0]   w_win_exp;
   logic [DW-1:0]   w_win_mod;

   logic            w_accept;
   logic            w_reject;
   logic            w_take;
   logic            w_timeout;
   logic            w_resp_hs;
   logic            w_wd_expire;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .i_req   (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_win_base = bus.req_base[w_idx*DW +: DW];
   assign w_win_exp  = bus.req_exp[w_idx*DW +: DW];
   assign w_win_mod  = bus.req_mod[w_idx*DW +: DW];

`ifdef ARB_WATCHDOG_EN
   logic [15:0] r_wd_cnt;

   // Expiry is flagged on the BUSY cycle whose increment would reach TIMEOUT.
   assign w_wd_expire = (r_state == BUSY) && (r_wd_cnt == TIMEOUT - 16'd1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wd_cnt <= '0;
      end else if (r_state == LAUNCH) begin
         r_wd_cnt <= '0;
      end else if (r_state == BUSY) begin
         r_wd_cnt <= r_wd_cnt + 16'd1;
      end
   end
`else
   logic [15:0] w_unused_timeout;

   assign w_unused_timeout = TIMEOUT;
   assign w_wd_expire      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      w_take       = 1'b0;
      w_timeout    = 1'b0;
      w_resp_hs    = 1'b0;
      case (r_state)
         IDLE: begin
            // req_ready mirrors the grant here, so any pending request is a handshake.
            if (w_any) begin
               if (w_win_mod == '0) begin
                  w_reject     = 1'b1;
                  w_state_next = RESP;
               end else begin
                  w_accept     = 1'b1;
                  w_state_next = LAUNCH;
               end
            end
         end
         LAUNCH: begin
            w_state_next = BUSY;
         end
         BUSY: begin
            if (bus.eng_done) begin
               w_take       = 1'b1;
               w_state_next = RESP;
            end else if (w_wd_expire) begin
               w_timeout    = 1'b1;
               w_state_next = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready[r_owner]) begin
               w_resp_hs    = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rr_ptr   <= '0;
         r_owner    <= '0;
         r_eng_base <= '0;
         r_eng_exp  <= '0;
         r_eng_mod  <= '0;
         r_resp_r   <= '0;
         r_resp_err <= 1'b0;
      end else begin
         if (w_accept || w_reject) begin
            r_owner <= w_idx;
         end
         if (w_accept) begin
            r_eng_base <= w_win_base;
            r_eng_exp  <= w_win_exp;
            r_eng_mod  <= w_win_mod;
         end
         if (w_reject || w_timeout) begin
            r_resp_r   <= '0;
            r_resp_err <= 1'b1;
         end else if (w_take) begin
            r_resp_r   <= bus.eng_r;
            r_resp_err <= 1'b0;
         end
         if (w_resp_hs) begin
            r_rr_ptr <= (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
         end
      end
   end

   assign bus.req_ready  = (r_state == IDLE) ? w_grant : '0;
   assign bus.resp_valid = (r_state == RESP) ? (NREQ'(1) << r_owner) : '0;
   assign bus.resp_r     = r_resp_r;
   assign bus.resp_err   = r_resp_err;
   assign bus.eng_start  = (r_state == LAUNCH);
   assign bus.eng_base   = r_eng_base;
   assign bus.eng_exp    = r_eng_exp;
   assign bus.eng_mod    = r_eng_mod;
   assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rsa_exp_arbiter.sv
// Self-checking bench for rsa_exp_arbiter with a latency-programmable engine model
// and a round-robin/modexp reference; watchdog cases run when ARB_WATCHDOG_EN is defined.
module tb_rsa_exp_arbiter;

   localparam int NREQ       = 4;
   localparam int DW         = 32;
   localparam int TB_TIMEOUT = 100;
`ifdef ARB_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   rsa_exp_arbiter_if #(.NREQ(NREQ), .DW(DW)) ifc ();

   rsa_exp_arbiter #(
      .NREQ    (NREQ),
      .DW      (DW),
      .TIMEOUT (16'd100)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (ifc)
   );

   int          n_pass = 0;
   int          n_fail = 0;
   int          n_total = 0;
   int          m_ptr = 0;
   logic [31:0] s_base [NREQ];
   logic [31:0] s_exp  [NREQ];
   logic [31:0] s_mod  [NREQ];
   int          eng_lat = 1;
   int          eng_cnt = 0;
   int          start_cnt = 0;
   logic [31:0] eng_pend = '0;
   bit          stray_pulse = 1'b0;
   int          last_win = -1;
   logic [31:0] last_r = '0;
   int          job_no = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                          input logic [31:0] m);
      longint unsigned r, x, mm;
      if (m == 32'd0) return 32'd0;
      mm = 64'(m);
      r  = 64'd1 % mm;
      x  = 64'(b) % mm;
      for (int i = 0; i < 32; i++) begin
         if (e[i]) r = (r * x) % mm;
         x = (x * x) % mm;
      end
      return r[31:0];
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      if (i >= 0 && i < NREQ) v[i] = 1'b1;
      return v;
   endfunction

   // Round robin: first requester with valid, scanning upward from the pointer.
   function automatic int ref_pick(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [31:0] rnd_mod();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   task automatic load(input int i, input logic [31:0] b, input logic [31:0] e,
                       input logic [31:0] m);
      s_base[i] = b;
      s_exp[i]  = e;
      s_mod[i]  = m;
      ifc.req_base[i*DW +: DW] = b;
      ifc.req_exp[i*DW +: DW]  = e;
      ifc.req_mod[i*DW +: DW]  = m;
      ifc.req_valid[i] = 1'b1;
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_req_ready"},  ifc.req_ready, '0);
      chk({p, "_resp_valid"}, ifc.resp_valid, '0);
      chk({p, "_resp_r"},     ifc.resp_r, '0);
      chk({p, "_resp_err"},   ifc.resp_err, 1'b0);
      chk({p, "_eng_start"},  ifc.eng_start, 1'b0);
      chk({p, "_eng_base"},   ifc.eng_base, '0);
      chk({p, "_eng_exp"},    ifc.eng_exp, '0);
      chk({p, "_eng_mod"},    ifc.eng_mod, '0);
      chk({p, "_busy"},       ifc.busy, 1'b0);
   endtask

   // Engine model: done pulse lat cycles after the start cycle; lat 0 never answers.
   initial begin
      ifc.eng_done = 1'b0;
      ifc.eng_r    = '0;
      forever begin
         @(negedge clk);
         ifc.eng_done = 1'b0;
         if (!rstn) begin
            eng_cnt = 0;
         end else begin
            if (eng_cnt > 0) begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                  ifc.eng_done = 1'b1;
                  ifc.eng_r    = eng_pend;
               end
            end
            if (ifc.eng_start) begin
               start_cnt++;
               eng_pend = modexp(ifc.eng_base, ifc.eng_exp, ifc.eng_mod);
               eng_cnt  = eng_lat;
            end
            if (stray_pulse) begin
               ifc.eng_done = 1'b1;
               ifc.eng_r    = 32'hDEAD_BEEF;
               stray_pulse  = 1'b0;
            end
         end
      end
   end

   // Entered just after a rising edge with the DUT in IDLE; returns the same way.
   task automatic serve(input int lat, input bit keep, input int bp);
      int          win, n, nexp, bound, s0;
      bit          found, to;
      logic [31:0] b, e, m, rexp;
      logic        rerr;
      eng_lat = lat;
      found   = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
         @(negedge clk);
         if (w == 0) chk("idle_busy", ifc.busy, 1'b0);
         found = (ifc.req_ready != '0);
      end
      win = ref_pick(ifc.req_valid);
      chk("grant", ifc.req_ready, onehot(win));
      if (!found || win < 0) return;
      b    = s_base[win];
      e    = s_exp[win];
      m    = s_mod[win];
      to   = WD_ON && (m != 0) && (lat == 0 || lat > TB_TIMEOUT);
      rerr = (m == 0) || to;
      rexp = rerr ? 32'd0 : modexp(b, e, m);
      s0   = start_cnt;
      @(posedge clk); #1;
      if (keep) load(win, $urandom, $urandom, rnd_mod());
      else      ifc.req_valid[win] = 1'b0;
      @(negedge clk);
      if (m == 0) begin
         chk("rej_eng_start", ifc.eng_start, 1'b0);
      end else begin
         chk("eng_start", ifc.eng_start, 1'b1);
         chk("eng_base", ifc.eng_base, b);
         chk("eng_exp",  ifc.eng_exp, e);
         chk("eng_mod",  ifc.eng_mod, m);
         nexp  = to ? TB_TIMEOUT + 1 : lat + 1;
         bound = nexp + 20;
         n     = 0;
         while (ifc.resp_valid == '0 && n < bound) begin
            @(negedge clk);
            n++;
         end
         chk("resp_latency", n, nexp);
      end
      chk("resp_valid", ifc.resp_valid, onehot(win));
      chk("resp_r",     ifc.resp_r, rexp);
      chk("resp_err",   ifc.resp_err, rerr);
      last_win = win;
      last_r   = ifc.resp_r;
      for (int k = 0; k < bp; k++) begin
         @(posedge clk); #1;
         ifc.resp_ready = ~onehot(win);
         if (k == 2) stray_pulse = 1'b1;
         @(negedge clk);
         chk("bp_resp_valid", ifc.resp_valid, onehot(win));
         chk("bp_resp_r",     ifc.resp_r, rexp);
         chk("bp_resp_err",   ifc.resp_err, rerr);
         chk("bp_req_ready",  ifc.req_ready, '0);
      end
      @(posedge clk); #1;
      ifc.resp_ready = onehot(win);
      @(negedge clk);
      chk("resp_hs_valid", ifc.resp_valid, onehot(win));
      @(posedge clk); #1;
      ifc.resp_ready = '0;
      m_ptr = (win + 1) % NREQ;
      if (m == 0) chk("rej_no_start", start_cnt, s0);
      $display("job %0d: req=%0d base=%08h exp=%08h mod=%08h lat=%0d -> r=%08h err=%0b",
               job_no, win, b, e, m, lat, last_r, rerr);
      job_no++;
   endtask

   initial begin
      bit found;
      rstn           = 1'b0;
      ifc.req_valid  = '0;
      ifc.req_base   = '0;
      ifc.req_exp    = '0;
      ifc.req_mod    = '0;
      ifc.resp_ready = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset("por");
      @(posedge clk); #1;
      rstn = 1'b1;

      // Single job from requester 0.
      load(0, 32'd4, 32'd13, 32'd497);
      serve(40, 1'b0, 0);
      chk("single_r", last_r, 32'd445);

      // Zero modulus rejected without engine start.
      load(2, 32'd7, 32'd9, 32'd0);
      serve(5, 1'b0, 0);

      // Backpressure with stray eng_done during RESP.
      load(3, 32'd12345, 32'd65537, 32'd1000003);
      serve(8, 1'b0, 10);

      // Fairness: all four requesters keep valid asserted.
      for (int i = 0; i < NREQ; i++) load(i, $urandom, $urandom, 32'd999983 + 32'(i));
      for (int k = 0; k < 5; k++) begin
         serve(3, 1'b1, 0);
         chk("fair_order", last_win, k % NREQ);
      end
      for (int k = 0; k < NREQ; k++) serve(2, 1'b0, 0);

      // Reset in the middle of BUSY.
      load(1, 32'd7, 32'd3, 32'd11);
      eng_lat = 30;
      found   = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
         @(negedge clk);
         found = (ifc.req_ready != '0);
      end
      chk("rst_grant", ifc.req_ready, onehot(ref_pick(ifc.req_valid)));
      @(posedge clk); #1;
      ifc.req_valid[1] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rstn = 1'b0;
      @(negedge clk);
      chk_reset("mid_rst");
      @(posedge clk); #1;
      rstn  = 1'b1;
      m_ptr = 0;
      for (int i = 0; i < NREQ; i++) load(i, $urandom, $urandom, 32'd65521);
      serve(6, 1'b0, 0);
      chk("post_rst_win", last_win, 0);
      for (int k = 1; k < NREQ; k++) serve(4, 1'b0, 0);

      // Randomized traffic against the reference model.
      for (int j = 0; j < 25; j++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!ifc.req_valid[i] && $urandom_range(0, 1) == 1)
               load(i, $urandom, $urandom, rnd_mod());
         end
         if (ifc.req_valid == '0) load($urandom_range(0, NREQ - 1), $urandom, $urandom, rnd_mod());
         serve($urandom_range(1, 20), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

`ifdef ARB_WATCHDOG_EN
      // Engine never answers: watchdog reports an error.
      load(2, 32'd3, 32'd5, 32'd1000);
      serve(0, 1'b0, 0);
      // Done lands on the expiry cycle: normal result wins.
      load(2, 32'd3, 32'd5, 32'd1000);
      serve(TB_TIMEOUT, 1'b0, 0);
      chk("wd_tie_r", last_r, 32'd243);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
